// File: rtl/psx_pad_responder.sv
// PSX pad protocol sequencer: tracks one poll per port and decides ack/reply per command byte.
// Replies and acks leave through a fixed two-stage pipeline so RAM data can be fetched in between.
module psx_pad_responder #(
    parameter int LAST_DIGITAL = 4,
    parameter int LAST_ANALOG  = 8
) (
    input  logic       clk,
    input  logic       reset,
    input  logic [1:0] cmd_port,
    input  logic [4:0] cmd_index,
    input  logic [7:0] cmd_byte,
    input  logic       cmd_strobe,
    input  logic [3:0] analog_mode,
    output logic [4:0] ram_addr,
    input  logic [7:0] ram_data,
    output logic [1:0] reply_port,
    output logic [7:0] reply_byte,
    output logic       reply_strobe,
    output logic [1:0] ack_port,
    output logic       ack_strobe,
    output logic [7:0] port_state
);

    // Strobe semantics: cmd_* are valid only in the cycle cmd_strobe is high. There is
    // no back-pressure; reply_strobe/ack_strobe pulse exactly two cycles after the strobe.
    typedef enum logic [1:0] {
        ST_IDLE      = 2'd0,
        ST_ADDRESSED = 2'd1,
        ST_POLL      = 2'd2,
        ST_IGNORE    = 2'd3
    } pad_state_t;

    pad_state_t state_q [4];
    logic [3:0] analog_q;

    pad_state_t cur_state;
    pad_state_t next_state;
    logic       next_analog;
    logic [4:0] last_index;
    logic       respond;
    logic       is_data;
    logic [7:0] const_byte;
    logic [4:0] addr_q;

    logic       s1_valid;
    logic [1:0] s1_port;
    logic       s1_data;
    logic [7:0] s1_const;

    assign cur_state  = state_q[cmd_port];
    assign last_index = analog_q[cmd_port] ? 5'(LAST_ANALOG) : 5'(LAST_DIGITAL);

    // State register: only the addressed port moves, so interleaved ports stay independent.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            for (int i = 0; i < 4; i++) state_q[i] <= ST_IDLE;
            analog_q <= 4'b0000;
        end else if (cmd_strobe) begin
            state_q[cmd_port]  <= next_state;
            analog_q[cmd_port] <= next_analog;
        end
    end

    always_comb begin
        next_state  = cur_state;
        next_analog = analog_q[cmd_port];
        if (cmd_index == 5'd0) begin
            next_state = (cmd_byte == 8'h01) ? ST_ADDRESSED : ST_IGNORE;
        end else if (cmd_index == 5'd1) begin
            if (cur_state == ST_ADDRESSED && cmd_byte == 8'h42) begin
                next_state  = ST_POLL;
                next_analog = analog_mode[cmd_port];
            end else if (cur_state != ST_IDLE) begin
                next_state = ST_IGNORE;
            end
        end else if (cur_state == ST_POLL && cmd_index == last_index) begin
            next_state = ST_IDLE;
        end
    end

    always_comb begin
        respond    = 1'b0;
        is_data    = 1'b0;
        const_byte = 8'hFF;
        if (cmd_index == 5'd0) begin
            if (cmd_byte == 8'h01) begin
                respond    = 1'b1;
                const_byte = analog_mode[cmd_port] ? 8'h73 : 8'h41;
            end
        end else if (cmd_index == 5'd1) begin
            if (cur_state == ST_ADDRESSED && cmd_byte == 8'h42) begin
                respond    = 1'b1;
                const_byte = 8'h5A;
            end
        end else if (cur_state == ST_POLL && cmd_index < last_index) begin
            respond = 1'b1;
            is_data = 1'b1;
        end
    end

    // Address is combinational in the strobe cycle so RAM data lands in time for stage 2.
    assign ram_addr = cmd_strobe ? {cmd_port, 3'(cmd_index - 5'd2)} : addr_q;

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            addr_q   <= 5'd0;
            s1_valid <= 1'b0;
            s1_port  <= 2'd0;
            s1_data  <= 1'b0;
            s1_const <= 8'hFF;
        end else begin
            s1_valid <= cmd_strobe & respond;
            if (cmd_strobe) begin
                addr_q   <= ram_addr;
                s1_port  <= cmd_port;
                s1_data  <= is_data;
                s1_const <= const_byte;
            end
        end
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            reply_strobe <= 1'b0;
            ack_strobe   <= 1'b0;
            reply_port   <= 2'd0;
            ack_port     <= 2'd0;
            reply_byte   <= 8'hFF;
        end else begin
            reply_strobe <= s1_valid;
            ack_strobe   <= s1_valid;
            if (s1_valid) begin
                reply_port <= s1_port;
                ack_port   <= s1_port;
                reply_byte <= s1_data ? ram_data : s1_const;
            end
        end
    end

    always_comb begin
        for (int i = 0; i < 4; i++) port_state[2*i +: 2] = state_q[i];
    end

endmodule

// File: tb/tb_psx_pad_responder.sv
// Self-checking bench for psx_pad_responder: a protocol model predicts every reply/ack
// with its due cycle, and a negedge monitor pops and compares them.
module tb_psx_pad_responder;

    localparam int W = 26;  // {due_cycle[15:0], port[1:0], byte[7:0]}

    logic       clk = 1'b0;
    logic       reset = 1'b1;
    logic [1:0] cmd_port = 2'd0;
    logic [4:0] cmd_index = 5'd0;
    logic [7:0] cmd_byte = 8'h00;
    logic       cmd_strobe = 1'b0;
    logic [3:0] analog_mode = 4'b0000;
    logic [4:0] ram_addr;
    logic [7:0] ram_data = 8'h00;
    logic [1:0] reply_port;
    logic [7:0] reply_byte;
    logic       reply_strobe;
    logic [1:0] ack_port;
    logic       ack_strobe;
    logic [7:0] port_state;

    logic [7:0]   ram [32];
    logic [W-1:0] exp_q [$];
    int           checks = 0;
    int           errors = 0;
    int           cyc = 0;

    // reference model: 0 idle, 1 addressed, 2 poll, 3 ignore
    int m_state [4];
    int m_last  [4];

    psx_pad_responder dut (
        .clk(clk), .reset(reset),
        .cmd_port(cmd_port), .cmd_index(cmd_index), .cmd_byte(cmd_byte),
        .cmd_strobe(cmd_strobe), .analog_mode(analog_mode),
        .ram_addr(ram_addr), .ram_data(ram_data),
        .reply_port(reply_port), .reply_byte(reply_byte), .reply_strobe(reply_strobe),
        .ack_port(ack_port), .ack_strobe(ack_strobe), .port_state(port_state)
    );

    // clock / reset block
    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;
    always @(posedge clk) ram_data <= ram[ram_addr];

    // scoreboard monitor
    always @(negedge clk) begin
        if (!reset) begin
            if (exp_q.size() > 0 && int'(exp_q[0][25:10]) == cyc) begin
                logic [W-1:0] e;
                e = exp_q.pop_front();
                checks++;
                if (reply_strobe !== 1'b1 || ack_strobe !== 1'b1 || reply_port !== e[9:8] ||
                    ack_port !== e[9:8] || reply_byte !== e[7:0]) begin
                    errors++;
                    $display("FAIL reply cyc=%0d: got rs=%b as=%b port=%0d/%0d byte=%02h, want port=%0d byte=%02h",
                             cyc, reply_strobe, ack_strobe, reply_port, ack_port, reply_byte, e[9:8], e[7:0]);
                end
            end else if (reply_strobe !== 1'b0 || ack_strobe !== 1'b0) begin
                checks++;
                errors++;
                $display("FAIL unexpected_strobe cyc=%0d: got rs=%b as=%b port=%0d byte=%02h, want none",
                         cyc, reply_strobe, ack_strobe, reply_port, reply_byte);
            end
        end
    end

    task automatic model_reset();
        for (int i = 0; i < 4; i++) begin
            m_state[i] = 0;
            m_last[i]  = 4;
        end
    endtask

    task automatic push_exp(input logic [1:0] p, input logic [7:0] b);
        logic [15:0] due;
        due = 16'(cyc + 2);
        exp_q.push_back({due, p, b});
    endtask

    // driver: called at a negedge, holds the strobe for one cycle
    task automatic send(input logic [1:0] p, input int idx, input logic [7:0] b);
        cmd_port   = p;
        cmd_index  = 5'(idx);
        cmd_byte   = b;
        cmd_strobe = 1'b1;
        if (idx == 0) begin
            if (b == 8'h01) begin
                m_state[p] = 1;
                push_exp(p, analog_mode[p] ? 8'h73 : 8'h41);
            end else begin
                m_state[p] = 3;
            end
        end else if (idx == 1) begin
            if (m_state[p] == 1 && b == 8'h42) begin
                m_state[p] = 2;
                m_last[p]  = analog_mode[p] ? 8 : 4;
                push_exp(p, 8'h5A);
            end else if (m_state[p] != 0) begin
                m_state[p] = 3;
            end
        end else if (m_state[p] == 2) begin
            if (idx < m_last[p]) begin
                logic [4:0] a;
                a = {p, 3'(idx - 2)};
                push_exp(p, ram[a]);
            end else if (idx == m_last[p]) begin
                m_state[p] = 0;
            end
        end
        @(negedge clk);
    endtask

    task automatic idle(input int n);
        cmd_strobe = 1'b0;
        repeat (n) @(negedge clk);
    endtask

    task automatic drain(input string name);
        int budget;
        cmd_strobe = 1'b0;
        budget = 10;
        while (exp_q.size() > 0 && budget > 0) begin
            @(negedge clk);
            budget--;
        end
        repeat (3) @(negedge clk);
        checks++;
        if (exp_q.size() != 0) begin
            errors++;
            $display("FAIL %s drain: got %0d pending replies, want 0", name, exp_q.size());
            exp_q.delete();
        end
    endtask

    task automatic check_port_state(input string name, input logic [7:0] want);
        checks++;
        if (port_state !== want) begin
            errors++;
            $display("FAIL %s port_state: got %02h, want %02h", name, port_state, want);
        end
    endtask

    task automatic check_reset_outputs(input string name);
        checks++;
        if (ram_addr !== 5'd0 || reply_port !== 2'd0 || reply_byte !== 8'hFF ||
            reply_strobe !== 1'b0 || ack_port !== 2'd0 || ack_strobe !== 1'b0 ||
            port_state !== 8'h00) begin
            errors++;
            $display("FAIL %s outputs: got addr=%0d rp=%0d rb=%02h rs=%b ap=%0d as=%b ps=%02h, want 0 0 ff 0 0 0 00",
                     name, ram_addr, reply_port, reply_byte, reply_strobe, ack_port, ack_strobe, port_state);
        end
    endtask

    task automatic poll(input logic [1:0] p, input int last_idx);
        send(p, 0, 8'h01);
        send(p, 1, 8'h42);
        for (int k = 2; k <= last_idx; k++) send(p, k, 8'h00);
    endtask

    task automatic test_reset();
        reset = 1'b1;
        model_reset();
        repeat (3) @(negedge clk);
        check_reset_outputs("reset");
        reset = 1'b0;
        @(negedge clk);
        check_reset_outputs("after_reset");
    endtask

    task automatic test_digital_poll();
        analog_mode = 4'b0000;
        ram[16] = 8'hFE;
        ram[17] = 8'hFF;
        send(2'd2, 0, 8'h01);
        send(2'd2, 1, 8'h42);
        check_port_state("digital_in_poll", 8'h20);
        send(2'd2, 2, 8'h00);
        send(2'd2, 3, 8'h00);
        send(2'd2, 4, 8'h00);
        drain("digital");
        check_port_state("digital_idle", 8'h00);
        checks++;
        if (ram_addr !== 5'd18) begin
            errors++;
            $display("FAIL ram_addr_hold: got %0d, want 18", ram_addr);
        end
    endtask

    task automatic test_analog_poll();
        analog_mode = 4'b0001;
        for (int i = 0; i < 6; i++) ram[i] = 8'(8'h11 * (i + 1));
        poll(2'd0, 8);
        drain("analog");
        check_port_state("analog_idle", 8'h00);
    endtask

    task automatic test_bad_commands();
        analog_mode = 4'b0000;
        send(2'd1, 0, 8'h81);
        send(2'd1, 1, 8'h42);
        for (int k = 2; k <= 4; k++) send(2'd1, k, 8'h00);
        drain("bad_index0");
        send(2'd1, 0, 8'h01);
        send(2'd1, 1, 8'h43);
        for (int k = 2; k <= 4; k++) send(2'd1, k, 8'h00);
        drain("bad_index1");
        check_port_state("bad_ignore", 8'h0C);
    endtask

    task automatic test_interleave();
        analog_mode = 4'b1000;
        for (int i = 0; i < 8; i++) begin
            ram[8 + i]  = 8'($urandom_range(0, 255));
            ram[24 + i] = 8'($urandom_range(0, 255));
        end
        for (int k = 0; k <= 8; k++) begin
            logic [7:0] b;
            b = (k == 0) ? 8'h01 : (k == 1) ? 8'h42 : 8'h00;
            if (k <= 4) send(2'd1, k, b);
            send(2'd3, k, b);
        end
        drain("interleave");
        check_port_state("interleave_idle", 8'h00);
    endtask

    task automatic test_restart_overrun();
        analog_mode = 4'b0000;
        for (int i = 0; i < 8; i++) ram[16 + i] = 8'($urandom_range(0, 255));
        send(2'd2, 0, 8'h01);
        send(2'd2, 1, 8'h42);
        send(2'd2, 2, 8'h00);
        analog_mode = 4'b0100;
        send(2'd2, 0, 8'h01);
        analog_mode = 4'b0000;
        send(2'd2, 1, 8'h42);
        for (int k = 2; k <= 6; k++) send(2'd2, k, 8'h00);
        drain("restart_overrun");
        // mode flips between index 0 and 1: digital ID, analog length
        send(2'd0, 0, 8'h01);
        analog_mode = 4'b0001;
        send(2'd0, 1, 8'h42);
        for (int k = 2; k <= 8; k++) send(2'd0, k, 8'h00);
        drain("mode_change");
        check_port_state("restart_idle", 8'h00);
    endtask

    task automatic test_reset_mid_poll();
        analog_mode = 4'b0000;
        send(2'd3, 0, 8'h01);
        send(2'd3, 1, 8'h42);
        idle(3);
        send(2'd3, 2, 8'h00);
        cmd_strobe = 1'b0;
        reset = 1'b1;
        exp_q.delete();
        model_reset();
        @(negedge clk);
        check_reset_outputs("mid_poll_reset");
        @(negedge clk);
        reset = 1'b0;
        @(negedge clk);
        check_reset_outputs("mid_poll_release");
        send(2'd3, 1, 8'h42);
        send(2'd3, 2, 8'h00);
        drain("post_reset");
    endtask

    task automatic test_back_to_back_random();
        logic [7:0] bytes [4];
        bytes[0] = 8'h01;
        bytes[1] = 8'h42;
        bytes[2] = 8'h00;
        bytes[3] = 8'h81;
        for (int i = 0; i < 32; i++) ram[i] = 8'($urandom_range(0, 255));
        for (int n = 0; n < 120; n++) begin
            int idx;
            analog_mode = 4'($urandom_range(0, 15));
            idx = $urandom_range(0, 3) == 0 ? 0 : $urandom_range(1, 9);
            send(2'($urandom_range(0, 3)), idx,
                 (idx <= 1) ? bytes[$urandom_range(0, 1) == 0 ? idx : 3] : bytes[$urandom_range(2, 3)]);
        end
        drain("random");
    endtask

    initial begin
        model_reset();
        for (int i = 0; i < 32; i++) ram[i] = 8'h00;
        @(negedge clk);
        test_reset();
        test_digital_poll();
        test_analog_poll();
        test_bad_commands();
        test_interleave();
        test_restart_overrun();
        test_reset_mid_poll();
        test_back_to_back_random();
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
